updn_counter_p: RTL
===================

# updn_counter_p

Parameterised synchronous up/down counter with parallel load, count enable, programmable modulus, and a selectable wrap or saturate mode. It generalises the team's fixed 4-bit load/up/down counter to arbitrary width and modulus. It adds boundary-event reporting for downstream timers and sequencers. It sits directly in the datapath as a single-clock leaf block with no handshake.

## Interface
- Reset is synchronous and active-low; the reset port is named `rst` as in the rest of the codebase. All state is clocked by `clk`.
- Parameters:
  - WIDTH, default 8: counter width in bits; legal range ≥ 2.
  - MODULO, default 2**WIDTH: count range is 0..MODULO-1; legal range 2..2**WIDTH.
- Ports:
  - clk, input, 1: clock; all state updates on its rising edge.
  - rst, input, 1: synchronous active-low reset.
  - en, input, 1: count enable.
  - load, input, 1: parallel load strobe.
  - data, input, WIDTH: load value.
  - updown, input, 1: count direction; 1 = up, 0 = down.
  - sat, input, 1: boundary mode; 1 = saturate, 0 = wrap.
  - clr_flag, input, 1: clears ovf_flag.
  - step, input, WIDTH: count increment. Present only when UPDN_CNT_STEP_EN is defined.
  - data_out, output, WIDTH: registered count.
  - wrap, output, 1: registered one-cycle boundary-event pulse.
  - ovf_flag, output, 1: sticky boundary-event flag.
  - at_limit, output, 1: combinational; high when data_out equals MODULO-1 and updown=1, or when data_out equals 0 and updown=0.

## Operation
- Priority per clock edge: rst=0, then load, then en, then hold.
- Reset: data_out, wrap and ovf_flag all go to 0.
- Load: data_out ← min(data, MODULO-1); wrap ← 0. Load suppresses counting in that cycle.
- Count (en=1, load=0), with S = effective step:
  - Up: sum = data_out + S, computed WIDTH+1 bits wide.
    - If sum ≤ MODULO-1: next = sum.
    - Otherwise, boundary event: next = sum − MODULO in wrap mode, or MODULO-1 in saturate mode.
  - Down:
    - If S ≤ data_out: next = data_out − S.
    - Otherwise, boundary event: next = data_out + MODULO − S in wrap mode, or 0 in saturate mode.
  - A boundary event is any requested value outside 0..MODULO-1. This includes saturate-mode attempts made while already at the limit, e.g. 0 counting down.
  - S = 0 holds the count and never produces a boundary event.
- Hold (en=0, load=0): data_out unchanged; wrap ← 0.
- wrap ← 1 exactly in the cycle in which the boundary-event next value appears on data_out; otherwise 0.
- ovf_flag: set on a boundary event, cleared by clr_flag=1. If set and clear occur in the same cycle, set wins.
- updown, sat and step may change on any cycle and take effect on the next edge.

## Timing
- Single-cycle latency: the effect of inputs sampled at edge N is visible on data_out, wrap and ovf_flag after edge N.
- at_limit is combinational from data_out and updown; no registered delay.
- Reset mid-count: the next edge forces all outputs to 0 regardless of load and en. Counting resumes on the first edge with rst=1.
- No combinational path from data, load or en to any output.

## Configuration
- UPDN_CNT_STEP_EN:
  - Defined: step port exists; S = min(step, MODULO-1).
  - Undefined: step port is absent; S = 1 fixed.
  - All other behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=4, MODULO=10 unless noted.
- Reset: hold rst=0 for 2 cycles with en=1, load=1 → data_out=0, wrap=0, ovf_flag=0. Release rst and count up → 1, 2, 3.
- Up wrap: load 8, then en=1, updown=1, sat=0 for 3 cycles → data_out 9, 0, 1. wrap is high only with 0. ovf_flag=1 and stays set until clr_flag pulses.
- Down saturate: load 2, then en=1, updown=0, sat=1 for 4 cycles → 1, 0, 0, 0. wrap is high in the last two cycles. at_limit=1 once data_out=0.
- Load priority and clamp: load=1, en=1, data=12 → data_out=9, wrap=0. Then clr_flag=1 coincident with a boundary event → ovf_flag stays 1.
- Step (macro defined): load 8, step=3, up, wrap mode → 1, then 4. Down from 1 with step=3 → 8.
- Reset mid-count: with en=1 at count 5, assert rst=0 for one cycle → data_out=0 next edge, then 1.

Source files
------------

// File: rtl/updn_counter_p.sv
// ---------------------------------------------------------------------------
// updn_counter_p
//   Parameterised synchronous up/down counter. It supports parallel load,
//   count enable, a programmable modulus, and a wrap or saturate boundary mode.
//   It reports boundary events as a one-cycle pulse (wrap) and as a sticky
//   flag (ovf_flag).
//
//   Optional build macro:
//     UPDN_CNT_STEP_EN - when defined, the 'step' port exists and the
//                        effective increment is min(step, MODULO-1).
//                        When undefined, the increment is fixed at 1.
//
//   Parameters:
//     WIDTH  - counter width in bits (>= 2)
//     MODULO - count range is 0..MODULO-1 (2..2**WIDTH)
//
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous reset, active low
//     en       in   count enable
//     load     in   parallel load strobe (has priority over en)
//     data     in   load value, clamped to MODULO-1
//     updown   in   1 = count up, 0 = count down
//     sat      in   1 = saturate at the limits, 0 = wrap modulo MODULO
//     clr_flag in   clears ovf_flag (a coincident boundary event wins)
//     step     in   count increment (UPDN_CNT_STEP_EN builds only)
//     data_out out  registered count
//     wrap     out  registered pulse, high while a boundary-event value is shown
//     ovf_flag out  sticky boundary-event flag
//     at_limit out  combinational: count is at the limit for the current direction
// ---------------------------------------------------------------------------
module updn_counter_p #(
    parameter int WIDTH  = 8,
    parameter int MODULO = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             updown,
    input  logic             sat,
    input  logic             clr_flag,
`ifdef UPDN_CNT_STEP_EN
    input  logic [WIDTH-1:0] step,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             wrap,
    output logic             ovf_flag,
    output logic             at_limit
);

    // MODULO can be 2**WIDTH, so the modulus needs WIDTH+1 bits.
    // MODULO-1 always fits in WIDTH bits.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH:0]   sum;
    logic             bnd_evt;

    // Effective step. Clamping to MODULO-1 keeps a single wrap correction
    // enough to bring the result back into range.
`ifdef UPDN_CNT_STEP_EN
    always_comb begin
        step_eff = (step > MAX_V) ? MAX_V : step;
    end
`else
    always_comb begin
        step_eff = WIDTH'(1);
    end
`endif

    always_comb begin
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        bnd_evt = 1'b0;
        sum     = {1'b0, cnt_q} + {1'b0, step_eff};

        if (load) begin
            cnt_d = (data > MAX_V) ? MAX_V : data;
        end else if (en) begin
            if (updown) begin
                if (sum <= {1'b0, MAX_V}) begin
                    cnt_d = sum[WIDTH-1:0];
                end else begin
                    bnd_evt = 1'b1;
                    cnt_d   = sat ? MAX_V : WIDTH'(sum - MOD_W);
                end
            end else begin
                if (step_eff <= cnt_q) begin
                    cnt_d = cnt_q - step_eff;
                end else begin
                    bnd_evt = 1'b1;
                    cnt_d   = sat ? '0
                                  : WIDTH'({1'b0, cnt_q} + MOD_W - {1'b0, step_eff});
                end
            end
        end

        wrap_d = bnd_evt;
        // A boundary event takes priority over clr_flag in the same cycle.
        ovf_d  = bnd_evt | (ovf_q & ~clr_flag);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_out = cnt_q;
    assign wrap     = wrap_q;
    assign ovf_flag = ovf_q;
    assign at_limit = updown ? (cnt_q == MAX_V) : (cnt_q == '0);

endmodule
